// File: rtl/bp_be_pkg.sv
// Shared backend definitions used by the fe_queue checkpoint FIFO.
package bp_be_pkg;

  // Pointer width for an els-deep queue: index bits plus one wrap bit.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_ckpt_ptrs.sv
// Write, read and commit pointers with wrap bits, plus the occupancy flags
// derived from them.
module bp_be_fe_queue_ckpt_ptrs
  import bp_be_pkg::*;
#(
  parameter int els_p = 8,
  localparam int ptr_w_lp = ptr_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enq_i,
  input  logic                yumi_i,
  input  logic                commit_i,
  input  logic                rollback_i,
  input  logic                clr_i,
  output logic [ptr_w_lp-1:0] wptr_o,
  output logic [ptr_w_lp-1:0] rptr_o,
  output logic [ptr_w_lp-1:0] cptr_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                unread_o
);

  localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);

  logic [ptr_w_lp-1:0] wptr_reg, rptr_reg, cptr_reg;
  logic [ptr_w_lp-1:0] cptr_next;

  assign cptr_next = commit_i ? cptr_reg + 1'b1 : cptr_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cptr_reg <= '0;
    end else begin
      if (enq_i)
        wptr_reg <= wptr_reg + 1'b1;
      cptr_reg <= cptr_next;
      // Rollback lands on the commit point including this cycle's commit.
      if (rollback_i)
        rptr_reg <= cptr_next;
      else if (yumi_i)
        rptr_reg <= rptr_reg + 1'b1;
    end
  end

  assign wptr_o   = wptr_reg;
  assign rptr_o   = rptr_reg;
  assign cptr_o   = cptr_reg;
  assign full_o   = ((wptr_reg - cptr_reg) == els_lp);
  assign empty_o  = (cptr_reg == wptr_reg);
  assign unread_o = (rptr_reg != wptr_reg);

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE packet queue with speculative dequeue, commit, rollback
// and clear. Optional zero-latency bypass: define BP_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_ckpt
  import bp_be_pkg::*;
#(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               commit_i,
  input  logic               rollback_i,
  input  logic               clr_i,
  output logic               empty_o
);

  localparam int ptr_w_lp = ptr_width(els_p);
  localparam int idx_w_lp = ptr_w_lp - 1;

  logic [ptr_w_lp-1:0] wptr, rptr, cptr;
  logic                full, unread, enq;
  logic [width_p-1:0]  mem [els_p];
  logic [width_p-1:0]  mem_rd;

  assign fe_queue_ready_o = ~full;
  assign enq = fe_queue_v_i & fe_queue_ready_o;

  bp_be_fe_queue_ckpt_ptrs #(.els_p(els_p)) ptrs (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enq_i      (enq),
    .yumi_i     (fe_queue_yumi_i),
    .commit_i   (commit_i),
    .rollback_i (rollback_i),
    .clr_i      (clr_i),
    .wptr_o     (wptr),
    .rptr_o     (rptr),
    .cptr_o     (cptr),
    .full_o     (full),
    .empty_o    (empty_o),
    .unread_o   (unread)
  );

  // Contents are don't-care after clear, so storage is never reset.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem[wptr[idx_w_lp-1:0]] <= fe_queue_i;
  end

  assign mem_rd = mem[rptr[idx_w_lp-1:0]];

`ifdef BP_FE_QUEUE_BYPASS_EN
  logic bypass;
  // The bypassed packet is still written, so replay after rollback works.
  assign bypass       = ~unread & enq & ~clr_i & ~rollback_i;
  assign fe_queue_v_o = unread | bypass;
  assign fe_queue_o   = bypass ? fe_queue_i : mem_rd;
`else
  assign fe_queue_v_o = unread;
  assign fe_queue_o   = mem_rd;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("fe_queue: yumi without valid");
      assert (!(commit_i && (cptr == rptr)))
        else $error("fe_queue: commit with nothing read");
      assert (!(fe_queue_v_i && full && !clr_i))
        else $error("fe_queue: enqueue while full");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Directed scoreboard bench for bp_be_fe_queue_ckpt (els_p=8, width_p=16).
module tb_bp_be_fe_queue_ckpt;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] fe_queue_i;
  logic        fe_queue_v_i;
  logic        fe_queue_ready_o;
  logic [15:0] fe_queue_o;
  logic        fe_queue_v_o;
  logic        fe_queue_yumi_i;
  logic        commit_i;
  logic        rollback_i;
  logic        clr_i;
  logic        empty_o;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  bp_be_fe_queue_ckpt #(.els_p(8), .width_p(16)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .commit_i         (commit_i),
    .rollback_i       (rollback_i),
    .clr_i            (clr_i),
    .empty_o          (empty_o)
  );

  // Monitor: every effective consume is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset_i && fe_queue_yumi_i && !clr_i && !rollback_i) begin
      tests++;
      if (!fe_queue_v_o) begin
        fails++;
        $display("FAIL deq_valid: v_o=%0b required 1", fe_queue_v_o);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deq_unexpected: got %h, required no output", fe_queue_o);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (fe_queue_o !== e) begin
          fails++;
          $display("FAIL deq_data: got %h required %h", fe_queue_o, e);
        end else
          $display("[TB] deq %h ok", fe_queue_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else
      $display("[TB] %s = %h ok", name, act);
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic y,
                     input logic c, input logic r, input logic cl);
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    commit_i        = c;
    rollback_i      = r;
    clr_i           = cl;
    @(posedge clk);
    #1;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    commit_i        = 1'b0;
    rollback_i      = 1'b0;
    clr_i           = 1'b0;
  endtask

  task automatic enq(input logic [15:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmt();
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_i = 1'b1;
    fe_queue_i = '0; fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0;
    commit_i = 1'b0; rollback_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    chk("reset_ready", fe_queue_ready_o, 1);
    chk("reset_v_o", fe_queue_v_o, 0);
    chk("reset_empty", empty_o, 1);

    // In-order A, B, C with overlapped consume.
    enq(16'h00A0);
    chk("v_o_after_A", fe_queue_v_o, 1);
    exp_q.push_back(16'h00A0);
    cyc(1'b1, 16'h00B0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h00B0);
    cyc(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(16'h00C0);
    chk("abc_v_o_drained", fe_queue_v_o, 0);
    chk("abc_empty_read", empty_o, 0);
    cmt(); cmt();
    chk("abc_empty_2cmt", empty_o, 0);
    cmt();
    chk("abc_empty_3cmt", empty_o, 1);

    // Fill to full, drain reads, free one slot, wrap.
    clr();
    for (int i = 0; i < 8; i++) enq(16'h0010 + 16'(i));
    chk("full_ready", fe_queue_ready_o, 0);
    for (int i = 0; i < 8; i++) rd(16'h0010 + 16'(i));
    chk("full_ready_after_read", fe_queue_ready_o, 0);
    cmt();
    chk("ready_after_commit", fe_queue_ready_o, 1);
    enq(16'h0099);
    chk("wrap_full_again", fe_queue_ready_o, 0);
    rd(16'h0099);
    chk("wrap_v_o_drained", fe_queue_v_o, 0);

    // Rollback to commit point and replay.
    clr();
    for (int i = 1; i <= 5; i++) enq(16'h0030 + 16'(i));
    for (int i = 1; i <= 4; i++) rd(16'h0030 + 16'(i));
    cmt(); cmt();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rollback_out", fe_queue_o, 16'h0033);
    for (int i = 3; i <= 5; i++) rd(16'h0030 + 16'(i));
    cmt(); cmt(); cmt();
    chk("rollback_empty", empty_o, 1);

    // Commit and rollback in the same cycle.
    clr();
    for (int i = 1; i <= 4; i++) enq(16'h0040 + 16'(i));
    for (int i = 1; i <= 3; i++) rd(16'h0040 + 16'(i));
    cmt();
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("cmt_rb_v_o", fe_queue_v_o, 1);
    chk("cmt_rb_out", fe_queue_o, 16'h0043);
    rd(16'h0043); rd(16'h0044);
    cmt(); cmt();
    chk("cmt_rb_empty", empty_o, 1);

    // Clear overrides enqueue and yumi in the same cycle.
    clr();
    for (int i = 1; i <= 4; i++) enq(16'h0050 + 16'(i));
    cyc(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_empty", empty_o, 1);
    chk("clr_v_o", fe_queue_v_o, 0);
    chk("clr_ready", fe_queue_ready_o, 1);
    enq(16'h0056);
    rd(16'h0056);
    chk("clr_not_stored", fe_queue_v_o, 0);

`ifdef BP_FE_QUEUE_BYPASS_EN
    // Zero-latency bypass with same-cycle consume, then replay.
    clr();
    exp_q.push_back(16'h00D0);
    cyc(1'b1, 16'h00D0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("byp_v_o_next", fe_queue_v_o, 0);
    chk("byp_not_empty", empty_o, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("byp_replay_v_o", fe_queue_v_o, 1);
    chk("byp_replay_out", fe_queue_o, 16'h00D0);
    rd(16'h00D0);
    cmt();
    chk("byp_empty", empty_o, 1);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_ckpt.md
Name: bp_be_fe_queue_ckpt

Overview:
- Checkpointing FIFO between the frontend's fe_queue output and the backend issue stage.
- Buffers fe_queue packets and supports speculative dequeue: entries leave via a read pointer but are freed only on commit.
- Rollback rewinds the read pointer to the commit point so the backend can replay. Clear flushes everything on an fe_cmd redirect.

Parameters:
- els_p, 8, queue depth; power of two, >= 2.
- width_p, 128, packet width (set to fe_queue_width_lp by the instantiating core).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- fe_queue_i  in  width_p  packet from the FE.
- fe_queue_v_i  in  1  packet valid.
- fe_queue_ready_o  out  1  space available; connects to FE fe_queue_ready_i.
- fe_queue_o  out  width_p  packet at the read pointer.
- fe_queue_v_o  out  1  unread packet available.
- fe_queue_yumi_i  in  1  BE consumes fe_queue_o (speculative dequeue).
- commit_i  in  1  free the oldest read-but-uncommitted entry.
- rollback_i  in  1  read pointer := commit pointer.
- clr_i  in  1  flush all entries.
- empty_o  out  1  no entries held, read or unread.

Behaviour:
- Pointers and occupancy
  - Three pointers of clog2(els_p)+1 bits: wptr, rptr, cptr. The MSB is the wrap bit; the index is the low bits.
  - full = (wptr - cptr) == els_p, in modular pointer-width arithmetic.
  - Unread entries exist iff rptr != wptr. empty_o = (cptr == wptr).
- Enqueue
  - fe_queue_ready_o = ~full. It is independent of fe_queue_v_i and of same-cycle commit.
  - Enqueue fires on fe_queue_v_i & fe_queue_ready_o: mem[wptr] <= fe_queue_i and wptr++.
- Dequeue
  - fe_queue_v_o = (rptr != wptr). fe_queue_o = mem[rptr], read combinationally.
  - A packet enqueued in cycle N appears at the output in cycle N+1.
  - fe_queue_yumi_i is legal only when fe_queue_v_o is high; then rptr++.
- Commit
  - On commit_i, cptr++. This is legal only when cptr != rptr.
  - The entry is reusable for enqueue from the next cycle; full is evaluated on registered pointers.
- Rollback
  - rptr <= cptr (after any same-cycle commit increment).
  - Same-cycle yumi is ignored. fe_queue_v_o in the next cycle reflects the replayed entry.
- Clear
  - wptr, rptr and cptr <= 0.
  - Overrides enqueue, yumi, commit and rollback in the same cycle. The enqueued packet is dropped.
  - Storage contents are don't-care.
- Priority: reset > clr_i > rollback_i > (commit_i, fe_queue_yumi_i, enqueue). The last three update independently.
- Reset: all pointers 0. fe_queue_ready_o=1, fe_queue_v_o=0, empty_o=1. fe_queue_o is X/don't-care.
- Wrap-around: index wraps modulo els_p and the wrap bit toggles. A full queue with wptr index == cptr index is distinguished by the wrap bit.
- Simulation-only assertions (synthesis off):
  - yumi without v_o.
  - commit with cptr == rptr.
  - enqueue while full.

Optional Feature:
- BP_FE_QUEUE_BYPASS_EN
  - When defined: if rptr == wptr and fe_queue_v_i is high, fe_queue_v_o=1 and fe_queue_o=fe_queue_i in the same cycle (zero-latency path).
  - The packet is still written to mem[wptr] so commit and rollback semantics are unchanged. A same-cycle yumi advances rptr along with wptr.
  - clr_i or rollback_i in that cycle suppresses the bypass valid.
  - When undefined: minimum latency is 1 cycle, as above.

Decomposition:
- Shared package (bp_be_pkg):
  - Pointer-width localparam helper.
  - Packet typedef comes from the existing fe_queue struct macro; no new struct.
- Sub-module bp_be_fe_queue_ckpt_ptrs: holds the three wrap-bit pointers plus full/empty/valid logic.
- Storage: reuse the existing 1r1w sync-write / async-read register-file primitive.

Test Plan:
- Reset, then enqueue A, B, C on consecutive cycles.
  - fe_queue_v_o rises the cycle after A.
  - Yumi each cycle yields A, B, C in order; empty_o stays 0 until 3 commits, then 1.
- Fill 8 entries, no commits.
  - fe_queue_ready_o=0 after the 8th.
  - Read all 8: ready still 0.
  - One commit: ready=1 next cycle.
  - Enqueue a 9th: wraps to index 0 with wrap bit 1.
- Enqueue 5, yumi 4, commit 2, then rollback.
  - Next fe_queue_o is the 3rd packet; replay yields 3, 4, 5.
- Same cycle commit_i + rollback_i with 3 read / 1 committed.
  - rptr = cptr = 2; next output is packet 3.
- clr_i asserted in the same cycle as fe_queue_v_i and yumi, with 4 entries held.
  - Next cycle: empty_o=1, fe_queue_v_o=0; the incoming packet is not stored.
- With BP_FE_QUEUE_BYPASS_EN, empty queue, enqueue D with same-cycle yumi.
  - fe_queue_o=D and v_o=1 in the same cycle; next cycle v_o=0.
  - Rollback then replays D.
